// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: round-robin arbiter sharing the FP reg-file write port among FP units
module fp_wb_arbiter #(
   parameter int NUM_UNITS = 4,
   parameter int FLEN      = 32,
   parameter int ADDR_W    = 5,
   parameter int CNT_W     = 16,
   localparam int UW       = $clog2(NUM_UNITS)
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [NUM_UNITS-1:0]                req_valid,
   output logic [NUM_UNITS-1:0]                req_ready,
   input  logic [NUM_UNITS-1:0][ADDR_W-1:0]    req_rd,
   input  logic [NUM_UNITS-1:0][FLEN-1:0]      req_data,
   input  logic [NUM_UNITS-1:0][4:0]           req_fflags,
   input  logic                                wb_stall,
   output logic                                wb_valid,
   output logic [ADDR_W-1:0]                   wb_rd,
   output logic [FLEN-1:0]                     wb_data,
   output logic [4:0]                          wb_fflags,
   output logic [UW-1:0]                       wb_unit,
   output logic [CNT_W-1:0]                    contention_cnt
);
   logic [UW-1:0] rr_ptr, sel, idx;
   logic          xfer, multi;
   // scan from the highest offset down so the unit closest to rr_ptr wins
   always_comb begin
      sel = '0;
      idx = '0;
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
         idx = UW'((int'(rr_ptr) + k) % NUM_UNITS);
         if (req_valid[idx]) sel = idx;
      end
   end
   assign xfer      = reset_n & (|req_valid) & ~wb_stall;
   assign req_ready = xfer ? (NUM_UNITS'(1) << sel) : '0;
   assign multi     = |(req_valid & (req_valid - NUM_UNITS'(1)));
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wb_valid       <= 1'b0;
         wb_rd          <= '0;
         wb_data        <= '0;
         wb_fflags      <= '0;
         wb_unit        <= '0;
         rr_ptr         <= '0;
         contention_cnt <= '0;
      end else begin
         if (xfer) begin
            wb_valid  <= 1'b1;
            wb_rd     <= req_rd[sel];
            wb_data   <= req_data[sel];
            wb_fflags <= req_fflags[sel];
            wb_unit   <= sel;
            rr_ptr    <= (sel == UW'(NUM_UNITS - 1)) ? '0 : sel + UW'(1);
         end else if (!wb_stall) begin
            wb_valid <= 1'b0;
         end
         if (multi && !(&contention_cnt)) contention_cnt <= contention_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: randomized scoreboard bench for fp_wb_arbiter against a round-robin reference
module tb_fp_wb_arbiter;
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [4:0]  fl;
      logic [1:0]  unit;
   } beat_t;

   logic              clk = 1'b0, reset_n = 1'b0, wb_stall = 1'b0;
   logic [3:0]        v = '0;
   logic [3:0][4:0]   rd = '0;
   logic [3:0][31:0]  data = '0;
   logic [3:0][4:0]   fl = '0;
   logic [3:0]        rdy, rdy2;
   logic              wb_valid, wbv2;
   logic [4:0]        wb_rd, wbrd2, wb_fflags, wbfl2;
   logic [31:0]       wb_data, wbd2;
   logic [1:0]        wb_unit, wbu2;
   logic [15:0]       cnt16;
   logic [3:0]        cnt4;

   beat_t exp_q[$];
   int    n_chk = 0, n_fail = 0;
   int    ptr_m = 0, cnt_m = 0, xfer_u = -1;
   int    wait_m[4] = '{0, 0, 0, 0};
   bit    started = 0;

   fp_wb_arbiter #(.NUM_UNITS(4), .FLEN(32), .ADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(v), .req_ready(rdy), .req_rd(rd),
      .req_data(data), .req_fflags(fl), .wb_stall(wb_stall), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_fflags(wb_fflags), .wb_unit(wb_unit),
      .contention_cnt(cnt16));

   fp_wb_arbiter #(.NUM_UNITS(4), .FLEN(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
      .clk(clk), .reset_n(reset_n), .req_valid(v), .req_ready(rdy2), .req_rd(rd),
      .req_data(data), .req_fflags(fl), .wb_stall(wb_stall), .wb_valid(wbv2),
      .wb_rd(wbrd2), .wb_data(wbd2), .wb_fflags(wbfl2), .wb_unit(wbu2),
      .contention_cnt(cnt4));

   always #5 clk = ~clk;

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference: grant = first valid unit scanning from the pointer; issued beats queued
   always @(negedge clk) begin
      logic [3:0] exp_rdy;
      int worst;
      if (started) begin
         check("contention_cnt", cnt16, cnt_m > 65535 ? 65535 : cnt_m);
         check("contention_sat", cnt4, cnt_m > 15 ? 15 : cnt_m);
      end
      exp_rdy = '0;
      xfer_u = -1;
      if (reset_n && !wb_stall)
         for (int k = 0; k < 4; k++)
            if (xfer_u < 0 && v[(ptr_m + k) % 4]) xfer_u = (ptr_m + k) % 4;
      if (xfer_u >= 0) exp_rdy[xfer_u] = 1'b1;
      check("req_ready", rdy, exp_rdy);
      if (xfer_u >= 0) begin
         exp_q.push_back('{rd: rd[xfer_u], data: data[xfer_u], fl: fl[xfer_u], unit: 2'(xfer_u)});
         worst = 0;
         for (int j = 0; j < 4; j++) begin
            if (j == xfer_u || !v[j]) wait_m[j] = 0;
            else wait_m[j]++;
            if (wait_m[j] > worst) worst = wait_m[j];
         end
         check("fairness", worst <= 3, 1);
         ptr_m = (xfer_u + 1) % 4;
      end
      if (!reset_n) begin
         ptr_m = 0;
         cnt_m = 0;
         wait_m = '{0, 0, 0, 0};
         started = 1;
      end else if ($countones(v) >= 2) cnt_m++;
   end

   // monitor: a beat is consumed on wb_valid & ~wb_stall
   always @(negedge clk) begin
      beat_t b;
      if (started && wb_valid === 1'b1 && wb_stall === 1'b0) begin
         check("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("wb_rd", wb_rd, b.rd);
            check("wb_data", wb_data, b.data);
            check("wb_fflags", wb_fflags, b.fl);
            check("wb_unit", wb_unit, b.unit);
         end
      end
   end

   task automatic set_unit(int i, logic [4:0] r, logic [31:0] d, logic [4:0] f);
      v[i] = 1'b1;
      rd[i] = r;
      data[i] = d;
      fl[i] = f;
   endtask

   task automatic drive(int n, int pv, int ps);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (xfer_u >= 0) v[xfer_u] = 1'b0;
         for (int i = 0; i < 4; i++)
            if (!v[i] && $urandom_range(99) < pv)
               set_unit(i, 5'($urandom), $urandom, 5'($urandom));
         wb_stall = $urandom_range(99) < ps;
      end
   endtask

   task automatic reset_mid();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         if (!v[i]) set_unit(i, 5'($urandom), $urandom, 5'($urandom));
      wb_stall = 1'($urandom);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      v = '0;
      wb_stall = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_rd", wb_rd, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_wb_unit", wb_unit, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_wb_valid", wb_valid, 0);
      check("reset_wb_fflags", wb_fflags, 0);
      @(posedge clk);
      #1;
      set_unit(1, 5'd7, 32'h3F80_0000, 5'd0);
      drive(3, 0, 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) set_unit(i, 5'(i + 10), 32'hA000_0000 + i, 5'(i));
      drive(6, 0, 0);
      @(posedge clk);
      #1;
      set_unit(2, 5'd3, 32'hC0DE_0002, 5'h1F);
      @(posedge clk);
      #1;
      v[2] = 1'b0;
      set_unit(0, 5'd4, 32'h1234_5678, 5'h01);
      wb_stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall_hold_valid", wb_valid, 1);
         check("stall_hold_data", wb_data, 32'hC0DE_0002);
         @(posedge clk);
         #1;
      end
      wb_stall = 1'b0;
      drive(3, 0, 0);
      drive(300, 30, 20);
      reset_mid();
      drive(300, 80, 10);
      drive(60, 100, 0);
      reset_mid();
      drive(200, 50, 30);
      drive(20, 0, 0);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
